// File: rtl/ex_mem_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pkg
// Shared definitions for the EX/MEM pipeline stage:
//   - ALU control encodings used by the execute stage
//   - the EX/MEM payload record carried through the skid register
//   - the skid register state encoding
//   - branch resolution helper
// ----------------------------------------------------------------------------
package ex_mem_pkg;

    // The payload record is a fixed-layout packed struct, so its field widths
    // live here. The stage parameters default to these values.
    localparam int REC_DATA_W = 32;
    localparam int REC_ADDR_W = 5;

    // ALU control encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLLV = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_ORI  = 4'd8;
    localparam logic [3:0] ALU_BEQ  = 4'd9;
    localparam logic [3:0] ALU_BNE  = 4'd10;

    typedef struct packed {
        logic [REC_DATA_W-1:0] result;
        logic [REC_DATA_W-1:0] rt_data;
        logic [REC_ADDR_W-1:0] rd_addr;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_mem_rec_t;

    // Occupancy of the 2-entry skid register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // output invalid
        S_ONE   = 2'd1,   // output valid, skid empty
        S_FULL  = 2'd2    // output and skid both valid
    } skid_state_e;

    // beq is taken on zero, bne on non-zero.
    function automatic logic branch_taken(input logic is_branch,
                                          input logic zero,
                                          input logic is_ne);
        return is_branch & (zero ^ is_ne);
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry skid register for ex_mem_rec_t. The upstream ready is a flop, so
// there is no combinational path from ready_i to ready_o; the second entry
// absorbs the record accepted in the cycle the downstream stalls.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-low reset
//   flush_i  in   synchronous kill of both entries (highest priority)
//   valid_i  in   upstream record present
//   ready_o  out  registered; low only while both entries are held
//   data_i   in   upstream record
//   valid_o  out  output entry valid
//   ready_i  in   downstream accepts
//   data_o   out  output entry (held stable while stalled)
// ----------------------------------------------------------------------------
module pipe_skid_reg
    import ex_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  ex_mem_rec_t data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output ex_mem_rec_t data_o
);

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    logic        r_ready;
    logic        r_valid;
    ex_mem_rec_t r_out;
    ex_mem_rec_t r_skid;

    logic w_accept;
    logic w_send;
    logic w_load_out;
    logic w_load_out_from_skid;
    logic w_load_skid;

    assign w_accept = valid_i & r_ready;
    assign w_send   = r_valid & ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Flags are precomputed from the next state so both outputs come
            // straight from flops.
            r_ready <= (w_state_nxt != S_FULL);
            r_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_load_out           = 1'b0;
        w_load_out_from_skid = 1'b0;
        w_load_skid          = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_out  = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_send) begin
                        w_load_out = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_send) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // ready_o is low here, so nothing can be accepted.
                    if (w_send) begin
                        w_load_out_from_skid = 1'b1;
                        w_state_nxt          = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out <= '0;
        end else if (w_load_out) begin
            r_out <= data_i;
        end else if (w_load_out_from_skid) begin
            r_out <= r_skid;
        end
    end

    // The skid entry is only read while marked valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_load_skid) begin
            r_skid <= data_i;
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_out;

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline stage. Captures the ALU result and its control payload into
// a 2-entry skid register, resolves beq/bne from the zero flag, and counts
// retired records and stalled cycles.
//
// Ports:
//   clk_i, rst_i (async active-low), flush_i
//   valid_i / ready_o      upstream handshake, ready_o registered
//   alu_result_i, zero_i, rt_data_i, rd_addr_i, control bits, branch_i,
//   branch_ne_i, branch_target_i   EX record
//   valid_o / ready_i      downstream handshake
//   alu_result_o, rt_data_o, rd_addr_o, control bits   registered payload
//   branch_taken_o         one-cycle pulse the cycle after a taken branch is accepted
//   branch_target_o        target of the last taken branch
//   retire_cnt_o           records handed downstream (wraps)
//   stall_cnt_o            cycles with valid_o=1 and ready_i=0 (wraps)
// ----------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = REC_DATA_W,
    parameter int REG_ADDR_W = REC_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic                  zero_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_write_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  mem_to_reg_i,
    input  logic                  branch_i,
    input  logic                  branch_ne_i,
    input  logic [DATA_W-1:0]     branch_target_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_write_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  mem_to_reg_o,
    output logic                  branch_taken_o,
    output logic [DATA_W-1:0]     branch_target_o,
    output logic [CNT_W-1:0]      retire_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    ex_mem_rec_t       w_rec_in;
    ex_mem_rec_t       w_rec_out;
    logic              w_ready;
    logic              w_valid;
    logic              w_accept;
    logic              w_send;
    logic              w_take;

    logic              r_branch_taken;
    logic [DATA_W-1:0] r_branch_target;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    always_comb begin
        w_rec_in            = '0;
        w_rec_in.result     = alu_result_i;
        w_rec_in.rt_data    = rt_data_i;
        w_rec_in.rd_addr    = rd_addr_i;
        w_rec_in.reg_write  = reg_write_i;
        w_rec_in.mem_read   = mem_read_i;
        w_rec_in.mem_write  = mem_write_i;
        w_rec_in.mem_to_reg = mem_to_reg_i;
    end

    pipe_skid_reg u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (w_ready),
        .data_i  (w_rec_in),
        .valid_o (w_valid),
        .ready_i (ready_i),
        .data_o  (w_rec_out)
    );

    assign w_accept = valid_i & w_ready;
    assign w_send   = w_valid & ready_i;
    // A record presented during a flush is dropped, so it must not resolve.
    assign w_take   = w_accept & ~flush_i & branch_taken(branch_i, zero_i, branch_ne_i);

    // The pulse is driven from the accept cycle, not from the buffer, so it
    // never waits on downstream backpressure.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_branch_taken <= w_take;
            if (w_take) begin
                r_branch_target <= branch_target_i;
            end
        end
    end

    // A send on a flush cycle still counts: downstream already took the record.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_send) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_valid && !ready_i) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign ready_o         = w_ready;
    assign valid_o         = w_valid;
    assign alu_result_o    = w_rec_out.result;
    assign rt_data_o       = w_rec_out.rt_data;
    assign rd_addr_o       = w_rec_out.rd_addr;
    assign reg_write_o     = w_rec_out.reg_write;
    assign mem_read_o      = w_rec_out.mem_read;
    assign mem_write_o     = w_rec_out.mem_write;
    assign mem_to_reg_o    = w_rec_out.mem_to_reg;
    assign branch_taken_o  = r_branch_taken;
    assign branch_target_o = r_branch_target;
    assign retire_cnt_o    = r_retire_cnt;
    assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage. A queue-based model of the stage (records
// in flight, counters, branch pulse) is compared against the DUT on every
// falling edge; literal expectations at key points pin the model itself.
// Counters are built 8 bits wide so wrap-around is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk;
    logic          rst_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] alu_result_i;
    logic          zero_i;
    logic [DW-1:0] rt_data_i;
    logic [AW-1:0] rd_addr_i;
    logic          reg_write_i;
    logic          mem_read_i;
    logic          mem_write_i;
    logic          mem_to_reg_i;
    logic          branch_i;
    logic          branch_ne_i;
    logic [DW-1:0] branch_target_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] alu_result_o;
    logic [DW-1:0] rt_data_o;
    logic [AW-1:0] rd_addr_o;
    logic          reg_write_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic          mem_to_reg_o;
    logic          branch_taken_o;
    logic [DW-1:0] branch_target_o;
    logic [CW-1:0] retire_cnt_o;
    logic [CW-1:0] stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .alu_result_i    (alu_result_i),
        .zero_i          (zero_i),
        .rt_data_i       (rt_data_i),
        .rd_addr_i       (rd_addr_i),
        .reg_write_i     (reg_write_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .mem_to_reg_i    (mem_to_reg_i),
        .branch_i        (branch_i),
        .branch_ne_i     (branch_ne_i),
        .branch_target_i (branch_target_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .alu_result_o    (alu_result_o),
        .rt_data_o       (rt_data_o),
        .rd_addr_o       (rd_addr_o),
        .reg_write_o     (reg_write_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o),
        .retire_cnt_o    (retire_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } mrec_t;

    mrec_t       mq[$];
    int          m_ret;
    int          m_stall;
    logic        m_bt;
    logic [31:0] m_tgt;

    always @(posedge clk or negedge rst_i) begin
        int    occ;
        bit    acc;
        bit    snd;
        mrec_t r;
        if (!rst_i) begin
            mq.delete();
            m_ret   = 0;
            m_stall = 0;
            m_bt    = 1'b0;
            m_tgt   = '0;
        end else begin
            occ = mq.size();
            acc = valid_i && (occ < 2);
            snd = (occ > 0) && ready_i;
            if (snd) m_ret = (m_ret + 1) % (1 << CW);
            if (occ > 0 && !ready_i) m_stall = (m_stall + 1) % (1 << CW);
            m_bt = 1'b0;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (snd) void'(mq.pop_front());
                if (acc) begin
                    r.res = alu_result_i;
                    r.rt  = rt_data_i;
                    r.rd  = rd_addr_i;
                    r.rw  = reg_write_i;
                    r.mr  = mem_read_i;
                    r.mw  = mem_write_i;
                    r.m2r = mem_to_reg_i;
                    mq.push_back(r);
                    if (branch_i && (zero_i != branch_ne_i)) begin
                        m_bt  = 1'b1;
                        m_tgt = branch_target_i;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst_i) begin
            chk("m_valid", 32'(valid_o), 32'(mq.size() > 0));
            chk("m_ready", 32'(ready_o), 32'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk("m_result", alu_result_o, mq[0].res);
                chk("m_rt", rt_data_o, mq[0].rt);
                chk("m_rd", 32'(rd_addr_o), 32'(mq[0].rd));
                chk("m_ctl", {28'd0, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
                    {28'd0, mq[0].rw, mq[0].mr, mq[0].mw, mq[0].m2r});
            end
            chk("m_btaken", 32'(branch_taken_o), 32'(m_bt));
            chk("m_btarget", branch_target_o, m_tgt);
            chk("m_retire", 32'(retire_cnt_o), 32'(m_ret));
            chk("m_stall", 32'(stall_cnt_o), 32'(m_stall));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_rec(input logic [31:0] res, input logic [4:0] rd, input logic rw);
        valid_i         = 1'b1;
        alu_result_i    = res;
        rt_data_i       = res ^ 32'hA5A5_0000;
        rd_addr_i       = rd;
        reg_write_i     = rw;
        mem_read_i      = res[0];
        mem_write_i     = res[1];
        mem_to_reg_i    = res[2];
        branch_i        = 1'b0;
        branch_ne_i     = 1'b0;
        zero_i          = 1'b0;
        branch_target_i = res + 32'h100;
    endtask

    task automatic idle();
        valid_i  = 1'b0;
        branch_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive_rec(32'h0, 5'd0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_retire", 32'(retire_cnt_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt_o), 32'd0);
        chk("rst_btaken", 32'(branch_taken_o), 32'd0);
        chk("rst_result", alu_result_o, 32'd0);
        rst_i = 1'b1;

        // single record
        ready_i = 1'b1;
        drive_rec(32'h0000_0005, 5'd3, 1'b1);
        @(negedge clk);
        idle();
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_result", alu_result_o, 32'h5);
        chk("t1_rd", 32'(rd_addr_o), 32'd3);
        chk("t1_rw", 32'(reg_write_o), 32'd1);
        chk("t1_retire0", 32'(retire_cnt_o), 32'd0);
        @(negedge clk);
        chk("t1_retire1", 32'(retire_cnt_o), 32'd1);
        chk("t1_valid_gone", 32'(valid_o), 32'd0);

        // beq taken
        drive_rec(32'h9, 5'd0, 1'b0);
        branch_i = 1'b1; zero_i = 1'b1; branch_ne_i = 1'b0;
        branch_target_i = 32'h0000_0040;
        @(negedge clk);
        idle();
        chk("beq_pulse", 32'(branch_taken_o), 32'd1);
        chk("beq_target", branch_target_o, 32'h40);
        @(negedge clk);
        chk("beq_pulse_end", 32'(branch_taken_o), 32'd0);
        chk("beq_target_hold", branch_target_o, 32'h40);

        // bne with zero set: not taken
        drive_rec(32'hA, 5'd0, 1'b0);
        branch_i = 1'b1; zero_i = 1'b1; branch_ne_i = 1'b1;
        branch_target_i = 32'h0000_0080;
        @(negedge clk);
        idle();
        chk("bne_nopulse", 32'(branch_taken_o), 32'd0);
        chk("bne_target_hold", branch_target_o, 32'h40);
        @(negedge clk);
        chk("retire3", 32'(retire_cnt_o), 32'd3);

        // back-to-back A, B under backpressure
        ready_i = 1'b0;
        drive_rec(32'h11, 5'd1, 1'b1);
        @(negedge clk);
        drive_rec(32'h22, 5'd2, 1'b1);
        chk("bb_ready_one", 32'(ready_o), 32'd1);
        @(negedge clk);
        idle();
        chk("bb_ready_full", 32'(ready_o), 32'd0);
        chk("bb_out_a", alu_result_o, 32'h11);
        chk("bb_stall1", 32'(stall_cnt_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("bb_stall4", 32'(stall_cnt_o), 32'd4);
        chk("bb_out_a_hold", alu_result_o, 32'h11);
        ready_i = 1'b1;
        @(negedge clk);
        chk("bb_out_b", alu_result_o, 32'h22);
        chk("bb_valid_b", 32'(valid_o), 32'd1);
        chk("bb_ready_back", 32'(ready_o), 32'd1);
        @(negedge clk);
        chk("bb_drained", 32'(valid_o), 32'd0);
        chk("bb_retire5", 32'(retire_cnt_o), 32'd5);

        // flush a full buffer while C (a taken branch) is presented
        ready_i = 1'b0;
        drive_rec(32'h44, 5'd4, 1'b1);
        @(negedge clk);
        drive_rec(32'h55, 5'd5, 1'b1);
        @(negedge clk);
        drive_rec(32'h33, 5'd6, 1'b1);
        branch_i = 1'b1; zero_i = 1'b1; branch_ne_i = 1'b0;
        branch_target_i = 32'h0000_00C0;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        idle();
        chk("fl_valid", 32'(valid_o), 32'd0);
        chk("fl_ready", 32'(ready_o), 32'd1);
        chk("fl_nopulse", 32'(branch_taken_o), 32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_no_c", 32'(valid_o), 32'd0);
        end

        // flush while a taken branch would otherwise be accepted
        ready_i = 1'b0;
        drive_rec(32'h66, 5'd7, 1'b1);
        @(negedge clk);
        drive_rec(32'h77, 5'd8, 1'b0);
        branch_i = 1'b1; zero_i = 1'b0; branch_ne_i = 1'b1;
        branch_target_i = 32'h0000_00E0;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        idle();
        chk("fl1_nopulse", 32'(branch_taken_o), 32'd0);
        chk("fl1_target", branch_target_o, 32'h40);
        chk("fl1_valid", 32'(valid_o), 32'd0);

        // asynchronous reset while full
        drive_rec(32'h88, 5'd9, 1'b1);
        @(negedge clk);
        drive_rec(32'h99, 5'd10, 1'b1);
        branch_i = 1'b1; zero_i = 1'b1; branch_ne_i = 1'b0;
        @(negedge clk);
        idle();
        chk("ar_full", 32'(ready_o), 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_o), 32'd0);
        chk("ar_ready", 32'(ready_o), 32'd1);
        chk("ar_retire", 32'(retire_cnt_o), 32'd0);
        chk("ar_stall", 32'(stall_cnt_o), 32'd0);
        chk("ar_btaken", 32'(branch_taken_o), 32'd0);
        chk("ar_result", alu_result_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;

        // stall counter wrap (8-bit counter)
        ready_i = 1'b0;
        drive_rec(32'hAB, 5'd11, 1'b1);
        @(negedge clk);
        idle();
        chk("wr_start", 32'(stall_cnt_o), 32'd0);
        repeat (255) @(negedge clk);
        chk("wr_max", 32'(stall_cnt_o), 32'd255);
        @(negedge clk);
        chk("wr_wrap", 32'(stall_cnt_o), 32'd0);
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("wr_retire", 32'(retire_cnt_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Captures the ALU result, zero flag and the control/payload bits carried alongside them, and resolves beq/bne from the zero flag.
- Presents an EX/MEM record to the memory stage through a valid/ready handshake with a 2-entry skid buffer, so the ALU side sees a registered ready.
- Keeps retire and stall counters for lab measurement.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_ADDR_W, 5, destination register index width
CNT_W, 32, width of performance counters

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous kill of all held entries
valid_i  in  1  EX record present
ready_o  out  1  stage can accept; registered, equals NOT skid_valid
alu_result_i  in  DATA_W  ALU result
zero_i  in  1  ALU zero flag
rt_data_i  in  DATA_W  store data
rd_addr_i  in  REG_ADDR_W  write-back register
reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  control bits
branch_i  in  1  instruction is a conditional branch
branch_ne_i  in  1  1 = bne, 0 = beq
branch_target_i  in  DATA_W  computed target
valid_o  out  1  output record valid
ready_i  in  1  memory stage accepts
alu_result_o, rt_data_o  out  DATA_W  registered payload
rd_addr_o  out  REG_ADDR_W  registered payload
reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  registered payload
branch_taken_o  out  1  one-cycle pulse, branch resolved taken
branch_target_o  out  DATA_W  target, valid with branch_taken_o
retire_cnt_o  out  CNT_W  records handed downstream
stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0, except ready_o=1. Counters 0. Both entries invalid.
- accept = valid_i & ready_o; send = valid_o & ready_i.
- States: EMPTY (out invalid), ONE (out valid, skid empty), FULL (both valid).
- EMPTY: accept loads the out register; go to ONE.
- ONE:
  - accept & send: out reloaded from input; stay ONE.
  - accept & !send: input goes to skid; go to FULL. ready_o falls next cycle.
  - !accept & send: go to EMPTY.
  - otherwise hold.
- FULL: send moves skid to out; go to ONE; ready_o rises next cycle. No accept is possible because ready_o=0.
- Output payload is stable while valid_o=1 and ready_i=0. No combinational path from ready_i to ready_o.
- Latency: 1 cycle from accept to valid_o when the stage is EMPTY or sending.
- Branch resolution:
  - taken = branch_i & (zero_i XOR branch_ne_i), evaluated on the accept cycle.
  - branch_taken_o=1 and branch_target_o=branch_target_i on the next cycle for exactly one cycle, independent of ready_i and of buffer occupancy.
  - branch_target_o holds its last value otherwise.
  - The branch record still propagates downstream, with reg_write as supplied.
- flush_i (priority over everything):
  - clears out-valid and skid-valid; ready_o=1 next cycle.
  - A record presented on the flush cycle is dropped and produces no branch_taken_o.
  - Payload registers need not clear.
  - send on the flush cycle is still counted: the downstream sampled it.
- Counters:
  - retire_cnt_o increments on send; stall_cnt_o increments when valid_o & !ready_i.
  - Both wrap modulo 2^CNT_W and are cleared only by reset.
- Reset mid-operation drops all entries immediately; no pulse is emitted.

Decomposition:
- Package ex_mem_pkg holds:
  - ALU control constants: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLTU=5, SLLV=6, LUI=7, ORI=8, BEQ=9, BNE=10.
  - A packed typedef ex_mem_rec_t for the payload: result, rt_data, rd_addr and the four control bits.
- One sub-module, pipe_skid_reg: a generic 2-entry skid register over ex_mem_rec_t with valid/ready and flush. ex_mem_stage adds branch resolution and counters around it.

Test Plan:
- Reset then single record: result 0x0000_0005, rd=3, reg_write=1, ready_i=1 -> valid_o=1 next cycle with those values; retire_cnt_o=1 one cycle later.
- beq with zero_i=1, target 0x0000_0040 -> branch_taken_o pulses one cycle with target 0x40. Same with branch_ne_i=1 -> no pulse.
- Back-to-back records A=0x11, B=0x22, ready_i held 0 -> out=A, skid=B, ready_o=0 after 2 cycles, stall_cnt_o counting. Release ready_i -> A then B delivered in order, ready_o=1.
- Full buffer plus flush_i=1 with valid_i=1 (C=0x33) -> valid_o=0 next cycle, C never appears, ready_o=1.
- Assert rst_i=0 between clock edges while FULL -> valid_o=0, ready_o=1 and counters 0 immediately, without waiting for a clock edge.
- Preload stall_cnt_o near wrap (force 0xFFFF_FFFF) and stall one cycle -> reads 0.
